tse_mm_arbiter: RTL

TSE_MM_ARBITER -- requirements
Module: tse_mm_arbiter

---
 rtl/tse_mm_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/tse_mm_arbiter.sv
// Two-port round-robin arbiter in front of the TSE Avalon-MM management port.
// Each transfer is bounded by a waitrequest timeout; completion is reported as a one-cycle ack.
module tse_mm_arbiter #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [9:0]  adr0,
  input  logic [9:0]  adr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [9:0]  ADR_O,
  output logic [31:0] DAT_O,
  output logic        RD,
  output logic        WR,
  input  logic [31:0] DAT_I,
  input  logic        BUSY
);

  // The timer holds the number of BUSY cycles already seen, so the abort fires
  // on the edge that ends the TIMEOUT_CYC-th BUSY cycle.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_reg;
  logic        grant_reg;
  logic        last_grant_reg;
  logic        read_reg;
  logic        timed_out_reg;
  logic [15:0] timer_reg;
  logic [31:0] cap_reg;
  logic [1:0]  ack_reg;
  logic [1:0]  err_reg;
  logic [31:0] rdata_reg [2];

  logic [1:0]  req_v;
  logic [1:0]  we_v;
  logic [9:0]  adr_v   [2];
  logic [31:0] wdata_v [2];
  logic        pick;

  assign req_v      = {req1, req0};
  assign we_v       = {we1, we0};
  assign adr_v[0]   = adr0;
  assign adr_v[1]   = adr1;
  assign wdata_v[0] = wdata0;
  assign wdata_v[1] = wdata1;

  assign ack0   = ack_reg[0];
  assign ack1   = ack_reg[1];
  assign err0   = err_reg[0];
  assign err1   = err_reg[1];
  assign rdata0 = rdata_reg[0];
  assign rdata1 = rdata_reg[1];

  // On contention the port that was not served last wins.
  always_comb begin
    pick = 1'b0;
    if (req_v == 2'b11) begin
      pick = ~last_grant_reg;
    end else if (req_v[1]) begin
      pick = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      read_reg       <= 1'b0;
      timed_out_reg  <= 1'b0;
      timer_reg      <= '0;
      cap_reg        <= '0;
      ack_reg        <= '0;
      err_reg        <= '0;
      rdata_reg[0]   <= '0;
      rdata_reg[1]   <= '0;
      ADR_O          <= '0;
      DAT_O          <= '0;
      RD             <= 1'b0;
      WR             <= 1'b0;
    end else begin
      ack_reg <= '0;
      err_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (|req_v) begin
            grant_reg      <= pick;
            last_grant_reg <= pick;
            ADR_O          <= adr_v[pick];
            DAT_O          <= wdata_v[pick];
            RD             <= ~we_v[pick];
            WR             <= we_v[pick];
            read_reg       <= ~we_v[pick];
            timed_out_reg  <= 1'b0;
            timer_reg      <= '0;
            state_reg      <= ACCESS;
          end
        end
        ACCESS: begin
          if (!BUSY) begin
            RD        <= 1'b0;
            WR        <= 1'b0;
            cap_reg   <= DAT_I;
            state_reg <= DONE;
          end else if (timer_reg == TIMER_LAST) begin
            RD            <= 1'b0;
            WR            <= 1'b0;
            cap_reg       <= '0;
            timed_out_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            timer_reg <= timer_reg + 16'd1;
          end
        end
        DONE: begin
          // rdata moves together with ack so it is stable between acks.
          ack_reg[grant_reg] <= 1'b1;
          err_reg[grant_reg] <= timed_out_reg;
          if (read_reg) begin
            rdata_reg[grant_reg] <= cap_reg;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
